// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit feeder and its byte FIFO.
//   state_e           - feeder FSM states (IDLE, LOAD, WAIT)
//   BYTE_W            - width of one UART data byte
//   FRAME_CLKS_9600   - clocks per 10-bit frame at 9600 baud from a 100 MHz clock
//   FRAME_CLKS_115200 - clocks per 10-bit frame at 115200 baud from a 100 MHz clock
package uart_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned FRAME_CLKS_9600   = 104170;
  localparam int unsigned FRAME_CLKS_115200 = 8680;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO with registered full/empty flags.
// Ports:
//   clk, n_rst       - rising-edge clock, asynchronous active-low reset
//   wr_en, wr_data   - push request and byte; ignored while full
//   rd_en, rd_data   - pop request and head byte (rd_data is the current head)
//   full, empty      - registered occupancy flags, updated with count
//   count            - registered occupancy, log2(DEPTH)+1 bits
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      wr_en,
  input  logic [BYTE_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [BYTE_W-1:0]         rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              wr_ok;
  logic              rd_ok;

  // Gating uses the registered flags, so a same-cycle pop never rescues a
  // write into a full FIFO.
  assign wr_ok = wr_en & ~full_q;
  assign rd_ok = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
    else if (!wr_ok && rd_ok) count_d = count_q - CW'(1);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host bytes and releases them to a UART transmitter
// one per frame, pulsing load and then waiting one full frame time because the
// UART has no busy indication.
// Ports:
//   clk, n_rst  - rising-edge clock, asynchronous active-low reset
//   sel         - baud select (0: FRAME_CLKS0, 1: FRAME_CLKS1), sampled at pop
//   wr_en       - host write strobe, wr_data the byte
//   full, empty - registered FIFO flags
//   ovf         - one-cycle pulse the cycle after a write is dropped
//   busy        - high while a frame is being loaded or timed
//   tx_data     - byte to the UART, held from pop until the next pop
//   load        - one-cycle load pulse to the UART
//   level       - registered FIFO occupancy (only with UART_TX_LEVEL_EN)
// Build option: define UART_TX_LEVEL_EN to add the level output.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned FRAME_CLKS0 = FRAME_CLKS_9600,
  parameter int unsigned FRAME_CLKS1 = FRAME_CLKS_115200,
  parameter int unsigned CNT_W       = 17
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              sel,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              busy,
  output logic [BYTE_W-1:0] tx_data,
  output logic              load
`ifdef UART_TX_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              sel_q, sel_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  logic              rd_en;
  logic [BYTE_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  uart_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The counter is loaded with FRAME-2 and WAIT exits on the edge where it
  // reaches zero, so IDLE can pop again exactly FRAME cycles after the
  // previous pop (LOAD and the IDLE pop cycle account for the other two).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    sel_d     = sel_q;
    rd_en     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          rd_en     = 1'b1;
          tx_data_d = fifo_rd_data;
          sel_d     = sel;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = (sel_q ? CNT_W'(FRAME_CLKS1) : CNT_W'(FRAME_CLKS0)) - CNT_W'(2);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    load_d = (state_q == LOAD);
    busy_d = (state_d != IDLE);
    ovf_d  = wr_en & fifo_full;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
      sel_q     <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      sel_q     <= sel_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign full    = fifo_full;
  assign empty   = fifo_empty;
  assign ovf     = ovf_q;
  assign busy    = busy_q;
  assign tx_data = tx_data_q;
  assign load    = load_q;

`ifdef UART_TX_LEVEL_EN
  assign level = fifo_count;
`else
  logic unused_level;
  assign unused_level = ^fifo_count;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized and directed stimulus for uart_tx_feeder,
// checked every cycle against a queue-and-timestamp reference model.
// Define UART_TX_LEVEL_EN to also exercise the level output.
module tb_uart_tx_feeder;

  localparam int DEPTH = 4;
  localparam int F0    = 40;
  localparam int F1    = 20;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       sel;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, ovf, busy, load;
  logic [7:0] tx_data;
`ifdef UART_TX_LEVEL_EN
  logic [2:0] level;
`endif

  uart_tx_feeder #(
    .DEPTH       (DEPTH),
    .FRAME_CLKS0 (F0),
    .FRAME_CLKS1 (F1),
    .CNT_W       (17)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .sel     (sel),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .busy    (busy),
    .tx_data (tx_data),
    .load    (load)
`ifdef UART_TX_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a byte queue, plus the edge of the last pop and the
  // earliest edge at which the next pop may happen.
  logic [7:0] q[$];
  int         edge_n;
  int         next_pop;
  int         last_pop;
  int         busy_end;
  bit         have_pop;
  logic [7:0] m_txd;
  bit         m_ovf;
  int         load_edges[$];
  int         ovf_seen;
  bit         cur_sel;

  task automatic model_reset();
    q.delete();
    have_pop = 1'b0;
    next_pop = 0;
    last_pop = 0;
    busy_end = 0;
    m_txd    = 8'h00;
    m_ovf    = 1'b0;
  endtask

  task automatic model_step(input bit w, input logic [7:0] d, input bit s);
    int pre_size;
    int f;
    edge_n++;
    pre_size = q.size();
    m_ovf = w && (pre_size == DEPTH);
    if (pre_size != 0 && edge_n >= next_pop) begin
      m_txd    = q.pop_front();
      f        = s ? F1 : F0;
      last_pop = edge_n;
      next_pop = edge_n + f;
      busy_end = edge_n + f - 2;
      have_pop = 1'b1;
    end
    if (w && pre_size < DEPTH) q.push_back(d);
  endtask

  task automatic compare();
    check("load",    {31'd0, load},  {31'd0, have_pop && (edge_n == last_pop + 1)});
    check("busy",    {31'd0, busy},  {31'd0, have_pop && edge_n >= last_pop && edge_n <= busy_end});
    check("tx_data", {24'd0, tx_data}, {24'd0, m_txd});
    check("ovf",     {31'd0, ovf},   {31'd0, m_ovf});
    check("full",    {31'd0, full},  {31'd0, q.size() == DEPTH});
    check("empty",   {31'd0, empty}, {31'd0, q.size() == 0});
`ifdef UART_TX_LEVEL_EN
    check("level",   {29'd0, level}, q.size());
`endif
    if (load === 1'b1) load_edges.push_back(edge_n);
    if (ovf === 1'b1) ovf_seen++;
  endtask

  // One clock: inputs applied shortly after the previous edge, model updated
  // at the edge, DUT sampled 1 time unit later.
  task automatic cycle(input bit w, input logic [7:0] d);
    wr_en   = w;
    wr_data = d;
    sel     = cur_sel;
    @(posedge clk);
    model_step(w, d, cur_sel);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_load"},    {31'd0, load},    32'd0);
    check({tag, "_busy"},    {31'd0, busy},    32'd0);
    check({tag, "_full"},    {31'd0, full},    32'd0);
    check({tag, "_empty"},   {31'd0, empty},   32'd1);
    check({tag, "_ovf"},     {31'd0, ovf},     32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
`ifdef UART_TX_LEVEL_EN
    check({tag, "_level"},   {29'd0, level},   32'd0);
`endif
  endtask

  logic [7:0] burst[3];
  int         k;

  initial begin
    burst[0] = 8'h92; burst[1] = 8'hA4; burst[2] = 8'h3C;
    n_rst = 1'b0; sel = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    cur_sel = 1'b0; edge_n = 0; ovf_seen = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    n_rst = 1'b1;

    // Single byte: load two edges after the write edge, frame of F0 cycles.
    load_edges.delete();
    cycle(1'b1, 8'h92);
    k = edge_n;
    idle(F0 + 5);
    check("single_nloads", load_edges.size(), 1);
    if (load_edges.size() == 1) check("single_latency", load_edges[0] - k, 2);
    check("single_txd", {24'd0, tx_data}, 32'h92);

    // Back-to-back burst: pulses exactly F0 apart, bytes in order.
    load_edges.delete();
    for (int i = 0; i < 3; i++) cycle(1'b1, burst[i]);
    for (int i = 0; i < 3; i++) begin
      while (load_edges.size() <= i && edge_n < k + 400) idle(1);
      check("burst_txd", {24'd0, tx_data}, {24'd0, burst[i]});
    end
    idle(F0);
    check("burst_nloads", load_edges.size(), 3);
    if (load_edges.size() == 3) begin
      check("burst_gap0", load_edges[1] - load_edges[0], F0);
      check("burst_gap1", load_edges[2] - load_edges[1], F0);
    end

    // Six writes into a DEPTH=4 FIFO: exactly one dropped.
    ovf_seen = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h10 + 8'(i));
    check("ovf_full", {31'd0, full}, 32'd1);
    idle(2);
    check("ovf_count", ovf_seen, 1);
    idle(6 * F0);

    // Baud change mid-frame: first gap stays F0, next frame uses F1.
    load_edges.delete();
    cur_sel = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h50 + 8'(i));
    idle(6);
    cur_sel = 1'b1;
    idle(2 * F0 + F1);
    check("sel_nloads", load_edges.size(), 3);
    if (load_edges.size() == 3) begin
      check("sel_gap0", load_edges[1] - load_edges[0], F0);
      check("sel_gap1", load_edges[2] - load_edges[1], F1);
    end
    idle(F0);

`ifdef UART_TX_LEVEL_EN
    // Occupancy while the FSM sits in WAIT, then draining one per pop.
    cycle(1'b1, 8'h01);
    idle(5);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h61 + 8'(i));
      check("level_fill", {29'd0, level}, i + 1);
    end
    idle(4 * F1 + 4);
`endif

    // Asynchronous reset mid-WAIT with bytes queued.
    cur_sel = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hC0 + 8'(i));
    idle(10);
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values("hold");
    n_rst = 1'b1;
    load_edges.delete();
    idle(F0 + 10);
    check("post_rst_nloads", load_edges.size(), 0);

    // Random traffic with random baud select.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 3) cur_sel = ~cur_sel;
      cycle($urandom_range(0, 99) < 8, 8'($urandom));
    end
    idle(5 * F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
